uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver. It captures each completed character on the rising edge of the receiver's done level (DONEo/DATAo) and stores it in a DEPTH-entry circular FIFO. Stored characters are presented to the consumer through a first-word-fall-through valid/ready read port. The block also reports fill level, full and empty status, and a sticky overflow flag, so characters are not lost while the consumer is stalled.

## Interface
- DATA_WDTH, 8, character width; must match the receiver's DATA_WDTH.
- DEPTH, 16, number of FIFO entries; power of two, ≥ 2.

- CLKip  input  1  clock, same domain as the receiver.
- rst  input  1  reset, synchronous, active-high.
- DONEi  input  1  receiver done level. High for multiple cycles per character.
- DATAi  input  DATA_WDTH  receiver data. Valid whenever DONEi is high.
- RD_READYi  input  1  consumer accepts the head entry.
- RD_VALIDo  output  1  head entry valid; equals not-empty.
- RD_DATAo  output  DATA_WDTH  head entry (oldest character).
- COUNTo  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH.
- FULLo  output  1  COUNTo == DEPTH.
- EMPTYo  output  1  COUNTo == 0.
- OVFo  output  1  sticky overflow flag.
- OVF_CLRi  input  1  clears OVFo.

## Operation
- Edge detect:
  - done_d registers DONEi every cycle.
  - push_req = DONEi & ~done_d. Exactly one request per DONEi high period, however long DONEi stays high.
  - done_d resets to 1. A DONEi level already high at reset release therefore produces no push.
- Storage:
  - Memory is mem[DEPTH], with wr_ptr and rd_ptr each $clog2(DEPTH) bits wide.
  - Both pointers wrap modulo DEPTH naturally.
  - count is a separate register of width $clog2(DEPTH+1).
- Pop:
  - pop = RD_VALIDo & RD_READYi.
  - A pop advances rd_ptr by 1.
  - RD_DATAo = mem[rd_ptr], read combinationally (first-word-fall-through).
  - RD_DATAo is don't-care while EMPTYo = 1.
- Push acceptance: push = push_req & (~FULLo | pop).
  - An accepted push writes DATAi into mem[wr_ptr] and advances wr_ptr by 1.
- Count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together, or neither: count unchanged.
- Full with simultaneous pop:
  - The push is accepted and no overflow is flagged.
  - Order is preserved: the popped entry leaves and the new entry goes at the tail.
- Empty with simultaneous push_req:
  - No pop occurs, because RD_VALIDo is 0.
  - The push is written and becomes visible the next cycle.
- Overflow:
  - push_req while FULLo = 1 and no pop sets OVFo.
  - The incoming character is dropped. FIFO contents and pointers are unchanged.
  - OVF_CLRi clears OVFo on the next clock.
  - If OVF_CLRi and a new overflow event occur in the same cycle, set wins and OVFo stays 1.
- RD_READYi while empty has no effect.
- Reset:
  - Clears wr_ptr, rd_ptr, count and OVFo, and sets done_d = 1.
  - Memory contents are not reset.
  - Reset values: RD_VALIDo = 0, EMPTYo = 1, FULLo = 0, COUNTo = 0, OVFo = 0. RD_DATAo is undefined.
  - Reset mid-operation discards all stored entries on the same clock edge.

## Timing
- Push latency:
  - DONEi first sampled high at edge N causes the write at edge N.
  - RD_VALIDo, COUNTo and RD_DATAo reflect the new entry after edge N, i.e. in cycle N+1.
- Pop:
  - Completes on the edge where RD_VALIDo & RD_READYi = 1.
  - The next entry appears on RD_DATAo in the following cycle, with no bubble.
- Throughput: the consumer can drain one entry per cycle. The UART fill rate is at most one entry per character time.
- Status outputs:
  - FULLo, EMPTYo and RD_VALIDo are decoded combinationally from registered count.
  - OVFo is registered.
- No combinational path from RD_READYi to RD_VALIDo or RD_DATAo.
- Consumer handshake rule: RD_DATAo must be held stable while RD_VALIDo = 1 and RD_READYi = 0. This follows from the pointer-only update.

## Test plan
- Single character:
  - Stimulus: DONEi held high for 20 cycles with DATAi = 0x5A, RD_READYi = 0.
  - Required: exactly one entry, COUNTo = 1, RD_DATAo = 0x5A, RD_VALIDo = 1 from the cycle after the first DONEi sample.
- Fill and overflow (DEPTH = 16):
  - Stimulus: push 0x00..0x0F, then one more push with DATAi = 0xFF while RD_READYi = 0.
  - Required: FULLo = 1, COUNTo = 16, OVFo = 1, then a drain returns 0x00..0x0F in order with 0xFF absent.
- Full push and pop together:
  - Stimulus: FIFO full, push_req with DATAi = 0xAA in the same cycle as RD_READYi = 1.
  - Required: OVFo stays 0, COUNTo stays 16, 0xAA is read out last after wrapping.
- Wrap-around:
  - Stimulus: 40 pushes interleaved with pops, keeping 1 to 3 entries stored.
  - Required: every byte is read out in order with no loss or duplication.
  - Required: EMPTYo = 1 and COUNTo = 0 at the end.
- Reset and flag clear:
  - Stimulus: reset with 5 entries stored while DONEi is high.
  - Required: after reset COUNTo = 0, EMPTYo = 1, OVFo = 0, and no push occurs until DONEi goes low then high.
  - Stimulus: overflow event in the same cycle as OVF_CLRi = 1.
  - Required: OVFo = 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer placed directly after the UART receiver.
// It captures one character on each rising edge of the receiver's done level
// and stores it in a DEPTH-entry circular FIFO. The consumer reads through a
// first-word-fall-through valid/ready port. The block also reports fill level,
// full and empty status, and a sticky overflow flag.
//
// Ports
//   CLKip      clock, same domain as the receiver
//   rst        synchronous, active-high reset
//   DONEi      receiver done level (high for several cycles per character)
//   DATAi      receiver data, valid while DONEi is high
//   RD_READYi  consumer accepts the head entry
//   RD_VALIDo  head entry valid (not empty)
//   RD_DATAo   head entry (oldest character)
//   COUNTo     number of stored entries, 0..DEPTH
//   FULLo      COUNTo == DEPTH
//   EMPTYo     COUNTo == 0
//   OVFo       sticky overflow flag (a character was dropped while full)
//   OVF_CLRi   clears OVFo on the next clock; a same-cycle overflow wins
module uart_rx_fifo #(
    parameter int unsigned DATA_WDTH = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                         CLKip,
    input  logic                         rst,
    input  logic                         DONEi,
    input  logic [DATA_WDTH-1:0]         DATAi,
    input  logic                         RD_READYi,
    output logic                         RD_VALIDo,
    output logic [DATA_WDTH-1:0]         RD_DATAo,
    output logic [$clog2(DEPTH+1)-1:0]   COUNTo,
    output logic                         FULLo,
    output logic                         EMPTYo,
    output logic                         OVFo,
    input  logic                         OVF_CLRi
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 done_d;
    logic                 ovf;

    logic push_req;
    logic pop;
    logic push;
    logic ovf_evt;

    // Status is decoded from the registered count only, so RD_READYi never
    // reaches RD_VALIDo or RD_DATAo combinationally.
    assign EMPTYo    = (count == CNT_W'(0));
    assign FULLo     = (count == CNT_W'(DEPTH));
    assign RD_VALIDo = ~EMPTYo;
    assign COUNTo    = count;
    assign OVFo      = ovf;
    assign RD_DATAo  = mem[rd_ptr];

    // One request per DONEi high period; a pop frees a slot in the same cycle.
    assign push_req = DONEi & ~done_d;
    assign pop      = RD_VALIDo & RD_READYi;
    assign push     = push_req & (~FULLo | pop);
    assign ovf_evt  = push_req & FULLo & ~pop;

    // Control state; done_d resets high so a level already high at reset
    // release is not treated as a new character.
    always_ff @(posedge CLKip) begin
        if (rst) begin
            done_d <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            done_d <= DONEi;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (OVF_CLRi) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge CLKip) begin
        if (push) begin
            mem[wr_ptr] <= DATAi;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: randomized character stimulus checked against a
// queue-based reference model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            CLKip = 1'b0;
    logic            rst;
    logic            DONEi;
    logic [DW-1:0]   DATAi;
    logic            RD_READYi;
    logic            RD_VALIDo;
    logic [DW-1:0]   RD_DATAo;
    logic [CW-1:0]   COUNTo;
    logic            FULLo;
    logic            EMPTYo;
    logic            OVFo;
    logic            OVF_CLRi;

    always #5 CLKip = ~CLKip;

    uart_rx_fifo #(.DATA_WDTH(DW), .DEPTH(DEPTH)) dut (
        .CLKip     (CLKip),
        .rst       (rst),
        .DONEi     (DONEi),
        .DATAi     (DATAi),
        .RD_READYi (RD_READYi),
        .RD_VALIDo (RD_VALIDo),
        .RD_DATAo  (RD_DATAo),
        .COUNTo    (COUNTo),
        .FULLo     (FULLo),
        .EMPTYo    (EMPTYo),
        .OVFo      (OVFo),
        .OVF_CLRi  (OVF_CLRi)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: stored characters in arrival order, sticky flag and
    // the previous DONEi level.
    logic [DW-1:0] q[$];
    logic          m_ovf    = 1'b0;
    logic          m_done_d = 1'b1;
    logic [CW+3:0] exp_st;

    // Advance model by one clock using the inputs currently applied, then
    // clock the DUT and settle 1 time unit after the edge.
    task automatic step();
        bit new_char;
        bit can_pop;
        bit was_full;
        new_char = DONEi && !m_done_d;
        can_pop  = (q.size() != 0) && RD_READYi;
        was_full = (q.size() == DEPTH);
        if (rst) begin
            q.delete();
            m_ovf    = 1'b0;
            m_done_d = 1'b1;
        end else begin
            if (can_pop) void'(q.pop_front());
            if (new_char && (!was_full || can_pop)) q.push_back(DATAi);
            if (new_char && was_full && !can_pop) m_ovf = 1'b1;
            else if (OVF_CLRi) m_ovf = 1'b0;
            m_done_d = DONEi;
        end
        @(posedge CLKip);
        #1;
    endtask

    // Present one character: DONEi high for hi cycles, then low one cycle.
    task automatic push_char(input logic [DW-1:0] d, input int hi);
        DONEi = 1'b1;
        DATAi = d;
        repeat (hi) step();
        DONEi = 1'b0;
        DATAi = DW'($urandom);
        step();
    endtask

    function automatic logic [CW+3:0] model_status();
        return {q.size() != 0, CW'(q.size()), q.size() == DEPTH, q.size() == 0, m_ovf};
    endfunction

    task automatic test_reset();
        rst = 1'b1; DONEi = 1'b0; DATAi = '0; RD_READYi = 1'b0; OVF_CLRi = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_st = {1'b0, CW'(0), 1'b0, 1'b1, 1'b0};
        n_total++;
        if ({RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== exp_st)
            $display("FAIL reset_status got %b want %b", {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo}, exp_st);
        else n_pass++;
    endtask

    task automatic test_single_char();
        DONEi = 1'b0;
        step();
        DONEi = 1'b1; DATAi = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            step();
            n_total++;
            if ({RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== model_status())
                $display("FAIL single_status cyc %0d got %b want %b", i, {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo}, model_status());
            else n_pass++;
            n_total++;
            if (COUNTo !== CW'(1) || RD_DATAo !== 8'h5A || RD_VALIDo !== 1'b1)
                $display("FAIL single_char cyc %0d count %0d data %h valid %b want 1 5a 1", i, COUNTo, RD_DATAo, RD_VALIDo);
            else n_pass++;
        end
        DONEi = 1'b0; RD_READYi = 1'b1;
        step();
        RD_READYi = 1'b0;
        n_total++;
        if (EMPTYo !== 1'b1 || COUNTo !== CW'(0))
            $display("FAIL single_drain empty %b count %0d want 1 0", EMPTYo, COUNTo);
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            push_char(DW'(i), int'($urandom_range(1, 3)));
            n_total++;
            if ({RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== model_status() || RD_DATAo !== q[0])
                $display("FAIL fill_status push %0d got %b/%h want %b/%h", i, {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo}, RD_DATAo, model_status(), q[0]);
            else n_pass++;
        end
        push_char(8'hFF, 2);
        n_total++;
        if (FULLo !== 1'b1 || COUNTo !== CW'(16) || OVFo !== 1'b1)
            $display("FAIL overflow full %b count %0d ovf %b want 1 16 1", FULLo, COUNTo, OVFo);
        else n_pass++;
        RD_READYi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (RD_DATAo !== DW'(i) || RD_VALIDo !== 1'b1)
                $display("FAIL drain_order idx %0d got %h valid %b want %h 1", i, RD_DATAo, RD_VALIDo, DW'(i));
            else n_pass++;
            step();
        end
        RD_READYi = 1'b0;
        n_total++;
        if (EMPTYo !== 1'b1 || COUNTo !== CW'(0) || OVFo !== 1'b1)
            $display("FAIL drain_end empty %b count %0d ovf %b want 1 0 1", EMPTYo, COUNTo, OVFo);
        else n_pass++;
        OVF_CLRi = 1'b1;
        step();
        OVF_CLRi = 1'b0;
        n_total++;
        if (OVFo !== 1'b0 || OVFo !== m_ovf)
            $display("FAIL ovf_clear got %b want 0", OVFo);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_char(DW'($urandom_range(0, 254)), 1);
        n_total++;
        if ({RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== model_status())
            $display("FAIL fpp_full got %b want %b", {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo}, model_status());
        else n_pass++;
        DONEi = 1'b1; DATAi = 8'hAA; RD_READYi = 1'b1;
        step();
        DONEi = 1'b0; RD_READYi = 1'b0;
        n_total++;
        if (OVFo !== 1'b0 || COUNTo !== CW'(16) || FULLo !== 1'b1)
            $display("FAIL fpp_status ovf %b count %0d full %b want 0 16 1", OVFo, COUNTo, FULLo);
        else n_pass++;
        RD_READYi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (RD_DATAo !== q[0] || (i == 15 && RD_DATAo !== 8'hAA))
                $display("FAIL fpp_drain idx %0d got %h want %h", i, RD_DATAo, (i == 15) ? 8'hAA : q[0]);
            else n_pass++;
            step();
        end
        RD_READYi = 1'b0;
        n_total++;
        if (EMPTYo !== 1'b1 || COUNTo !== CW'(0))
            $display("FAIL fpp_end empty %b count %0d want 1 0", EMPTYo, COUNTo);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 40; k++) begin
            DONEi = 1'b1; DATAi = DW'($urandom);
            RD_READYi = (q.size() >= 3) || (q.size() == 2 && $urandom_range(0, 1) == 1);
            step();
            DONEi = 1'b0;
            RD_READYi = (q.size() > 1) && ($urandom_range(0, 1) == 1);
            n_total++;
            if ({RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== model_status() || RD_DATAo !== q[0])
                $display("FAIL wrap_step %0d got %b/%h want %b/%h", k, {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo}, RD_DATAo, model_status(), q[0]);
            else n_pass++;
            step();
        end
        RD_READYi = 1'b1;
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            n_total++;
            if (RD_DATAo !== q[0])
                $display("FAIL wrap_drain idx %0d got %h want %h", i, RD_DATAo, q[0]);
            else n_pass++;
            step();
        end
        RD_READYi = 1'b0;
        n_total++;
        if (EMPTYo !== 1'b1 || COUNTo !== CW'(0) || q.size() != 0)
            $display("FAIL wrap_end empty %b count %0d want 1 0", EMPTYo, COUNTo);
        else n_pass++;
    endtask

    task automatic test_reset_flag_clear();
        for (int i = 0; i < 16; i++) push_char(DW'($urandom), 1);
        push_char(8'h77, 1);
        RD_READYi = 1'b1;
        repeat (11) step();
        RD_READYi = 1'b0;
        n_total++;
        if (COUNTo !== CW'(5) || OVFo !== 1'b1)
            $display("FAIL pre_reset count %0d ovf %b want 5 1", COUNTo, OVFo);
        else n_pass++;
        DONEi = 1'b1; DATAi = 8'h33; rst = 1'b1;
        step();
        rst = 1'b0; RD_READYi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (COUNTo !== CW'(0) || EMPTYo !== 1'b1 || OVFo !== 1'b0 || RD_VALIDo !== 1'b0)
                $display("FAIL post_reset cyc %0d count %0d empty %b ovf %b valid %b want 0 1 0 0", i, COUNTo, EMPTYo, OVFo, RD_VALIDo);
            else n_pass++;
            step();
        end
        RD_READYi = 1'b0;
        DONEi = 1'b0;
        step();
        DONEi = 1'b1; DATAi = 8'hC3;
        step();
        n_total++;
        if (COUNTo !== CW'(1) || RD_DATAo !== 8'hC3 || {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== model_status())
            $display("FAIL rearm count %0d data %h want 1 c3", COUNTo, RD_DATAo);
        else n_pass++;
        DONEi = 1'b0;
        step();
        for (int i = 0; i < 15; i++) push_char(DW'($urandom), 1);
        DONEi = 1'b1; DATAi = 8'hEE; OVF_CLRi = 1'b1;
        step();
        DONEi = 1'b0; OVF_CLRi = 1'b0;
        n_total++;
        if (OVFo !== 1'b1 || COUNTo !== CW'(16) || RD_DATAo !== 8'hC3)
            $display("FAIL set_wins ovf %b count %0d head %h want 1 16 c3", OVFo, COUNTo, RD_DATAo);
        else n_pass++;
        OVF_CLRi = 1'b1;
        step();
        OVF_CLRi = 1'b0;
        n_total++;
        if ({RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo} !== model_status() || OVFo !== 1'b0)
            $display("FAIL final_clear got %b want %b", {RD_VALIDo, COUNTo, FULLo, EMPTYo, OVFo}, model_status());
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; DONEi = 1'b0; DATAi = '0; RD_READYi = 1'b0; OVF_CLRi = 1'b0;
        test_reset();
        test_single_char();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_flag_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
